// File: rtl/sha256_pkg.sv
// Shared types and constants for the SHA-256 message padder.
// Block byte ordering is big-endian: message byte 0 occupies the top of the 512-bit block.
package sha256_pkg;

  typedef enum logic [1:0] {
    ST_FILL,
    ST_PAD,
    ST_LEN,
    ST_EMIT
  } state_e;

  typedef enum logic [1:0] {
    PEND_NONE,
    PEND_PAD0,
    PEND_LEN
  } pend_e;

  localparam int          BLK_BYTES = 64;
  localparam int          LEN_OFS   = 56;
  localparam logic [7:0]  PAD_BYTE  = 8'h80;

  // Byte i (LEN_OFS..BLK_BYTES-1) of the big-endian 64-bit length field.
  function automatic logic [7:0] len_byte(input logic [63:0] bits, input int i);
    return bits[(BLK_BYTES - 1 - i) * 8 +: 8];
  endfunction

endpackage

// File: rtl/sha256_msg_padder.sv
// Packs a byte stream into 512-bit SHA-256 message blocks with FIPS 180-4 padding.
// Byte side: valid/ready, transfer = byte_v_i & byte_ready_o; block side: valid/ready,
// transfer = blk_v_o & blk_ready_i, with blk_o/blk_first_o/blk_last_o stable while waiting.
module sha256_msg_padder
  import sha256_pkg::*;
#(
  parameter int len_bytes_width_p = 61
) (
  input  logic         clk_i,
  input  logic         reset_n_i,
  input  logic         byte_v_i,
  input  logic [7:0]   byte_i,
  input  logic         byte_last_i,
  output logic         byte_ready_o,
  output logic         blk_v_o,
  output logic [511:0] blk_o,
  output logic         blk_first_o,
  output logic         blk_last_o,
  input  logic         blk_ready_i,
  output logic         busy_o
);

  state_e                         state_q, state_d;
  pend_e                          pend_q, pend_d;
  logic [5:0]                     idx_q, idx_d;
  logic [len_bytes_width_p-1:0]   len_q, len_d;
  logic                           first_q, first_d;
  logic                           final_q, final_d;
  logic [7:0]                     blk_q [BLK_BYTES];
  logic [7:0]                     blk_d [BLK_BYTES];

  logic        byte_xfer;
  logic        blk_xfer;
  logic        fits_len;
  logic [63:0] len_bits;

  assign byte_xfer = byte_v_i & byte_ready_o;
  assign blk_xfer  = blk_v_o & blk_ready_i;
  // Length field fits in the same block when the pad byte lands at or below byte 55.
  assign fits_len  = (idx_q <= 6'(LEN_OFS - 1));
  assign len_bits  = 64'({len_q, 3'b000});

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q <= ST_FILL;
      pend_q  <= PEND_NONE;
      idx_q   <= '0;
      len_q   <= '0;
      first_q <= 1'b1;
      final_q <= 1'b0;
      for (int i = 0; i < BLK_BYTES; i++) blk_q[i] <= '0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      idx_q   <= idx_d;
      len_q   <= len_d;
      first_q <= first_d;
      final_q <= final_d;
      for (int i = 0; i < BLK_BYTES; i++) blk_q[i] <= blk_d[i];
    end
  end

  // Control path.
  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    idx_d   = idx_q;
    len_d   = len_q;
    first_d = first_q;
    final_d = final_q;
    unique case (state_q)
      ST_FILL: begin
        if (byte_xfer) begin
          idx_d = idx_q + 6'd1;
          len_d = len_q + len_bytes_width_p'(1);
          if (idx_q == 6'(BLK_BYTES - 1)) begin
            state_d = ST_EMIT;
            final_d = 1'b0;
            pend_d  = byte_last_i ? PEND_PAD0 : PEND_NONE;
          end else if (byte_last_i) begin
            state_d = ST_PAD;
          end
        end
      end
      ST_PAD: begin
        state_d = ST_EMIT;
        final_d = fits_len;
        pend_d  = fits_len ? PEND_NONE : PEND_LEN;
      end
      ST_LEN: begin
        state_d = ST_EMIT;
        final_d = 1'b1;
        pend_d  = PEND_NONE;
      end
      ST_EMIT: begin
        if (blk_xfer) begin
          first_d = 1'b0;
          if (final_q) begin
            state_d = ST_FILL;
            idx_d   = '0;
            len_d   = '0;
            first_d = 1'b1;
          end else if (pend_q == PEND_PAD0) begin
            state_d = ST_PAD;
            idx_d   = '0;
          end else if (pend_q == PEND_LEN) begin
            state_d = ST_LEN;
          end else begin
            state_d = ST_FILL;
            idx_d   = '0;
          end
        end
      end
      default: state_d = ST_FILL;
    endcase
  end

  // Block buffer: per-byte write enables; zero fill is a masked write above idx_q.
  always_comb begin
    for (int i = 0; i < BLK_BYTES; i++) begin
      blk_d[i] = blk_q[i];
      unique case (state_q)
        ST_FILL: begin
          if (byte_xfer && (6'(i) == idx_q)) blk_d[i] = byte_i;
        end
        ST_PAD: begin
          if (6'(i) == idx_q)     blk_d[i] = PAD_BYTE;
          else if (6'(i) > idx_q) blk_d[i] = 8'h00;
          if (fits_len && (i >= LEN_OFS)) blk_d[i] = len_byte(len_bits, i);
        end
        ST_LEN: begin
          blk_d[i] = (i >= LEN_OFS) ? len_byte(len_bits, i) : 8'h00;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    for (int i = 0; i < BLK_BYTES; i++) blk_o[511 - 8*i -: 8] = blk_q[i];
  end

  assign byte_ready_o = (state_q == ST_FILL);
  assign blk_v_o      = (state_q == ST_EMIT);
  assign blk_first_o  = blk_v_o & first_q;
  assign blk_last_o   = blk_v_o & final_q;
  assign busy_o       = (state_q != ST_FILL) || (idx_q != 6'd0);

endmodule

// File: tb/tb_sha256_msg_padder.sv
// Directed bench for sha256_msg_padder: hand-computed padded blocks, flags and latencies.
module tb_sha256_msg_padder;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         byte_v;
  logic [7:0]   byte_in;
  logic         byte_last;
  logic         byte_ready;
  logic         blk_v;
  logic [511:0] blk;
  logic         blk_first;
  logic         blk_last;
  logic         blk_ready;
  logic         busy;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0]   msg [64];
  logic [7:0]   eb  [64];
  logic [511:0] exp_blk;
  int           lat;
  int           seen;

  localparam logic [511:0] ABC_BLK = {32'h61626380, 416'h0, 64'h18};

  sha256_msg_padder #(.len_bytes_width_p(61)) dut (
    .clk_i        (clk),
    .reset_n_i    (reset_n),
    .byte_v_i     (byte_v),
    .byte_i       (byte_in),
    .byte_last_i  (byte_last),
    .byte_ready_o (byte_ready),
    .blk_v_o      (blk_v),
    .blk_o        (blk),
    .blk_first_o  (blk_first),
    .blk_last_o   (blk_last),
    .blk_ready_i  (blk_ready),
    .busy_o       (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp_v);
    n_checks++;
    assert (obs === exp_v) else begin
      n_fail++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    end
  endtask

  function automatic logic [511:0] pack_eb();
    logic [511:0] r;
    for (int i = 0; i < 64; i++) r[511 - 8*i -: 8] = eb[i];
    return r;
  endfunction

  task automatic clear_eb();
    for (int i = 0; i < 64; i++) eb[i] = 8'h00;
  endtask

  task automatic set_len(input logic [63:0] v);
    for (int k = 0; k < 8; k++) eb[56 + k] = v[63 - 8*k -: 8];
  endtask

  task automatic send_byte(input logic [7:0] b, input logic last);
    int guard = 0;
    @(negedge clk);
    byte_v = 1'b1; byte_in = b; byte_last = last;
    while (!byte_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 50) begin
      n_fail++;
      $display("FAIL byte_ready_timeout: observed 0 expected 1");
    end
    @(posedge clk);
    #1;
    byte_v = 1'b0; byte_last = 1'b0;
  endtask

  // Sends msg[0..n-1], last flag on the final byte when with_last is set.
  task automatic send_msg(input int n, input logic with_last);
    for (int i = 0; i < n; i++) send_byte(msg[i], with_last && (i == n - 1));
  endtask

  task automatic send_abc();
    send_byte(8'h61, 1'b0);
    send_byte(8'h62, 1'b0);
    send_byte(8'h63, 1'b1);
  endtask

  task automatic wait_blk(input string tag, output int l);
    l = 0;
    do begin
      @(negedge clk);
      l++;
    end while (!blk_v && l < 50);
    chk({tag, "_blk_v"}, 512'(blk_v), 512'(1'b1));
  endtask

  task automatic chk_blk(input string tag, input logic [511:0] e, input logic f, input logic l);
    chk({tag, "_blk"},   blk, e);
    chk({tag, "_first"}, 512'(blk_first), 512'(f));
    chk({tag, "_last"},  512'(blk_last),  512'(l));
  endtask

  // Block is taken at the next rising edge while blk_ready is high.
  task automatic consume();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset_n = 1'b0; byte_v = 1'b0; byte_in = 8'h00; byte_last = 1'b0; blk_ready = 1'b1;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    chk("rst_blk_v",      512'(blk_v), 512'(0));
    chk("rst_blk",        blk, 512'(0));
    chk("rst_first",      512'(blk_first), 512'(0));
    chk("rst_last",       512'(blk_last), 512'(0));
    chk("rst_byte_ready", 512'(byte_ready), 512'(1));
    chk("rst_busy",       512'(busy), 512'(0));

    // "abc": single final block two cycles after the last byte.
    send_abc();
    wait_blk("abc", lat);
    chk("abc_latency", 512'(lat), 512'(2));
    chk_blk("abc", ABC_BLK, 1'b1, 1'b1);
    consume();
    chk("abc_busy_after", 512'(busy), 512'(0));

    // 55 bytes: pad byte at 55 and length fit in one block.
    for (int i = 0; i < 64; i++) msg[i] = 8'(i);
    send_msg(55, 1'b1);
    wait_blk("m55", lat);
    clear_eb();
    for (int i = 0; i < 55; i++) eb[i] = 8'(i);
    eb[55] = 8'h80;
    set_len(64'h1B8);
    chk_blk("m55", pack_eb(), 1'b1, 1'b1);
    consume();

    // 56 bytes: pad in block 0, length-only block 1.
    send_msg(56, 1'b1);
    wait_blk("m56_b0", lat);
    clear_eb();
    for (int i = 0; i < 56; i++) eb[i] = 8'(i);
    eb[56] = 8'h80;
    chk_blk("m56_b0", pack_eb(), 1'b1, 1'b0);
    consume();
    wait_blk("m56_b1", lat);
    clear_eb();
    set_len(64'h1C0);
    chk_blk("m56_b1", pack_eb(), 1'b0, 1'b1);
    consume();

    // 64 bytes: full data block one cycle after byte 64, then 0x80 + length.
    send_msg(64, 1'b1);
    wait_blk("m64_b0", lat);
    chk("m64_latency", 512'(lat), 512'(1));
    for (int i = 0; i < 64; i++) eb[i] = 8'(i);
    chk_blk("m64_b0", pack_eb(), 1'b1, 1'b0);
    consume();
    wait_blk("m64_b1", lat);
    clear_eb();
    eb[0] = 8'h80;
    set_len(64'h200);
    chk_blk("m64_b1", pack_eb(), 1'b0, 1'b1);
    consume();

    // Back-pressure: block held stable, byte side stalled.
    blk_ready = 1'b0;
    send_abc();
    wait_blk("hold", lat);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk("hold_blk",        blk, ABC_BLK);
      chk("hold_blk_v",      512'(blk_v), 512'(1));
      chk("hold_byte_ready", 512'(byte_ready), 512'(0));
      chk("hold_first",      512'(blk_first), 512'(1));
    end
    blk_ready = 1'b1;
    consume();
    send_abc();
    wait_blk("abc2", lat);
    chk_blk("abc2", ABC_BLK, 1'b1, 1'b1);
    consume();

    // Reset mid-message: partial message discarded.
    for (int i = 0; i < 20; i++) msg[i] = 8'(8'hA0 + i);
    send_msg(20, 1'b0);
    chk("mid_busy", 512'(busy), 512'(1));
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk("rstmid_blk_v", 512'(blk_v), 512'(0));
    chk("rstmid_busy",  512'(busy), 512'(0));
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    seen = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (blk_v) seen++;
    end
    chk("rstmid_no_blk", 512'(seen), 512'(0));
    send_abc();
    wait_blk("abc3", lat);
    chk_blk("abc3", ABC_BLK, 1'b1, 1'b1);
    consume();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
